pulse_gen: RTL

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen_pkg.sv | 13 +
 rtl/cnt_down.sv | 27 ++
 rtl/pulse_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse burst generator.
package pulse_gen_pkg;

    localparam int W_TIME_DEF  = 16;
    localparam int W_COUNT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_down.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module cnt_down #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_gen.sv
// Burst generator: emits i_count pulses of i_high cycles separated by i_low cycles.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int W_TIME  = W_TIME_DEF,
    parameter int W_COUNT = W_COUNT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [W_TIME-1:0]  i_high,
    input  logic [W_TIME-1:0]  i_low,
    input  logic [W_COUNT-1:0] i_count,
    output logic               o_out,
    output logic               o_busy,
    output logic               o_done
);

    // Timer holds "cycles remaining minus one", so a zero duration still yields one cycle.
    function automatic logic [W_TIME-1:0] phaseLoad(input logic [W_TIME-1:0] dur);
        return (dur == '0) ? '0 : dur - W_TIME'(1);
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [W_TIME-1:0]  r_high;
    logic [W_TIME-1:0]  r_low;
    logic               r_out;
    logic               r_busy;
    logic               r_done;

    logic               w_latch;
    logic               w_doneNext;
    logic               w_timerLoad;
    logic [W_TIME-1:0]  w_timerVal;
    logic               w_timerDec;
    logic               w_timerZero;
    logic               w_pulseLoad;
    logic [W_COUNT-1:0] w_pulseVal;
    logic               w_pulseDec;
    logic               w_pulseZero;

    cnt_down #(.W(W_TIME)) u_phaseTimer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_timerLoad),
        .i_value (w_timerVal),
        .i_dec   (w_timerDec),
        .o_zero  (w_timerZero)
    );

    // Pulse counter holds pulses remaining after the current one.
    cnt_down #(.W(W_COUNT)) u_pulseCounter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_pulseLoad),
        .i_value (w_pulseVal),
        .i_dec   (w_pulseDec),
        .o_zero  (w_pulseZero)
    );

    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_doneNext  = 1'b0;
        w_timerLoad = 1'b0;
        w_timerVal  = '0;
        w_timerDec  = 1'b0;
        w_pulseLoad = 1'b0;
        w_pulseVal  = '0;
        w_pulseDec  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    w_latch = 1'b1;
                    if (i_count == '0) begin
                        w_doneNext = 1'b1;
                    end else begin
                        w_next      = HIGH;
                        w_timerLoad = 1'b1;
                        w_timerVal  = phaseLoad(i_high);
                        w_pulseLoad = 1'b1;
                        w_pulseVal  = i_count - W_COUNT'(1);
                    end
                end
            end
            HIGH: begin
                if (i_stop) begin
                    w_next = IDLE;
                end else if (w_timerZero) begin
                    if (w_pulseZero) begin
                        w_next     = IDLE;
                        w_doneNext = 1'b1;
                    end else begin
                        w_next      = LOW;
                        w_pulseDec  = 1'b1;
                        w_timerLoad = 1'b1;
                        w_timerVal  = phaseLoad(r_low);
                    end
                end else begin
                    w_timerDec = 1'b1;
                end
            end
            LOW: begin
                if (i_stop) begin
                    w_next = IDLE;
                end else if (w_timerZero) begin
                    w_next      = HIGH;
                    w_timerLoad = 1'b1;
                    w_timerVal  = phaseLoad(r_high);
                end else begin
                    w_timerDec = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_high  <= '0;
            r_low   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= (w_next == HIGH);
            r_busy  <= (w_next != IDLE);
            r_done  <= w_doneNext;
            if (w_latch) begin
                r_high <= i_high;
                r_low  <= i_low;
            end
        end
    end

    assign o_out  = r_out;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
